// File: rtl/booth4_seq_multiplier_if.sv
// booth4_seq_multiplier_if
// Bundles the operand handshake, abort, result handshake and busy flag of the
// iterative radix-4 Booth multiplier.
//   master : the producer/consumer side (drives operands, abort, out_ready)
//   slave  : the multiplier side (drives in_ready, out_valid, product, busy)
// Ports carried:
//   in_valid/in_ready   operand request / accept
//   a, b, signed_mode   multiplicand, multiplier, 1 = two's complement operands
//   abort               synchronous cancel
//   out_valid/out_ready result handshake
//   product             2*WIDTH-bit result
//   busy                operation in progress
interface booth4_seq_multiplier_if #(
  parameter int WIDTH = 16
) ();
  logic                 in_valid;
  logic                 in_ready;
  logic [WIDTH-1:0]     a;
  logic [WIDTH-1:0]     b;
  logic                 signed_mode;
  logic                 abort;
  logic                 out_valid;
  logic                 out_ready;
  logic [2*WIDTH-1:0]   product;
  logic                 busy;

  modport master (
    output in_valid, a, b, signed_mode, abort, out_ready,
    input  in_ready, out_valid, product, busy
  );

  modport slave (
    input  in_valid, a, b, signed_mode, abort, out_ready,
    output in_ready, out_valid, product, busy
  );
endinterface

// File: rtl/booth4_seq_multiplier.sv
// booth4_seq_multiplier
// Iterative radix-4 Booth multiplier retiring one recoded digit per clock.
// Operands are captured on accept, extended to WIDTH+2 bits (sign or zero
// extension by signed_mode) and multiplied over N = WIDTH/2+1 BUSY cycles.
// The result is held in DONE until out_ready, and in IDLE afterwards.
// Ports:
//   clk      rising-edge clock
//   reset_n  asynchronous active-low reset
//   bus      booth4_seq_multiplier_if slave modport (handshakes, operands,
//            abort, product, busy)
module booth4_seq_multiplier #(
  parameter int WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     reset_n,
  booth4_seq_multiplier_if.slave   bus
);

  localparam int N     = WIDTH / 2 + 1;
  localparam int EXT   = WIDTH + 2;
  localparam int ACC_W = 2 * WIDTH + 4;
  localparam int CNT_W = $clog2(N);
  localparam logic [CNT_W-1:0] LAST_DIGIT = CNT_W'(N - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e                    state_q, state_d;
  logic signed [ACC_W-1:0]   mcand_q, mcand_d;
  logic signed [ACC_W-1:0]   acc_q, acc_d;
  logic signed [ACC_W-1:0]   pp;
  logic [EXT:0]              mplier_q, mplier_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic [2*WIDTH-1:0]        product_q, product_d;
  logic [EXT-1:0]            a_ext, b_ext;
  logic                      accept;

  // Abort beats accept, so an abort in IDLE never starts an operation.
  assign accept = (state_q == IDLE) && bus.in_valid && !bus.abort;

  always_comb begin
    a_ext = bus.signed_mode ? {{2{bus.a[WIDTH-1]}}, bus.a} : {2'b00, bus.a};
    b_ext = bus.signed_mode ? {{2{bus.b[WIDTH-1]}}, bus.b} : {2'b00, bus.b};
  end

  // mplier_q keeps the implicit b[-1]=0 in bit 0, so its low three bits are
  // always the current Booth triplet; mcand_q already carries the 4^i weight.
  always_comb begin
    pp = '0;
    case (mplier_q[2:0])
      3'b001, 3'b010: pp = mcand_q;
      3'b011:         pp = mcand_q <<< 1;
      3'b100:         pp = -(mcand_q <<< 1);
      3'b101, 3'b110: pp = -mcand_q;
      default:        pp = '0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    product_d = product_q;

    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d  = BUSY;
          mcand_d  = {{(ACC_W-EXT){a_ext[EXT-1]}}, a_ext};
          mplier_d = {b_ext, 1'b0};
          cnt_d    = '0;
          acc_d    = '0;
        end
      end
      BUSY: begin
        acc_d    = acc_q + pp;
        mcand_d  = mcand_q <<< 2;
        mplier_d = {{2{mplier_q[EXT]}}, mplier_q[EXT:2]};
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == LAST_DIGIT) begin
          state_d   = DONE;
          product_d = acc_d[2*WIDTH-1:0];
        end
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // An abort on the final digit must not publish a partial result.
    if (bus.abort) begin
      state_d   = IDLE;
      product_d = product_q;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      mcand_q   <= '0;
      mplier_q  <= '0;
      cnt_q     <= '0;
      acc_q     <= '0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      product_q <= product_d;
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.busy      = (state_q != IDLE);
  assign bus.product   = product_q;

endmodule
